ibex_mem_arbiter: RTL
=====================

Name: ibex_mem_arbiter

Overview:
Two-to-one arbiter that shares a single req/gnt/rvalid memory port between the Ibex instruction-fetch and data (LSU) interfaces. Sits between the core top-level and a single-ported SRAM/bus host in small SoC configurations. Tracks the owner of every granted-but-unanswered transaction in an in-order FIFO, so responses are routed back to the correct requester. Arbitration is round-robin, and a pending request is locked until it is granted.

Parameters:
MaxOutstanding, 2, maximum granted transactions awaiting rvalid (>=1); depth of the owner FIFO
CntW, $clog2(MaxOutstanding+1), width of outstanding_o (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch grant
instr_rvalid_o  out  1  fetch response valid
instr_addr_i  in  32  fetch address
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch bus error
data_req_i  in  1  LSU request
data_gnt_o  out  1  LSU grant
data_rvalid_o  out  1  LSU response valid
data_we_i  in  1  LSU write enable
data_be_i  in  4  LSU byte enables
data_addr_i  in  32  LSU address
data_wdata_i  in  32  LSU write data
data_rdata_o  out  32  LSU read data
data_err_o  out  1  LSU bus error
mem_req_o  out  1  shared port request
mem_gnt_i  in  1  shared port grant
mem_rvalid_i  in  1  shared port response valid
mem_we_o  out  1  shared port write enable
mem_be_o  out  4  shared port byte enables
mem_addr_o  out  32  shared port address
mem_wdata_o  out  32  shared port write data
mem_rdata_i  in  32  shared port read data
mem_err_i  in  1  shared port error
outstanding_o  out  CntW  current FIFO occupancy
proto_err_o  out  1  sticky flag: rvalid received with no outstanding transaction

Behaviour:
- Reset: FIFO empty; outstanding_o=0; proto_err_o=0; lock cleared; rr_last=DATA, so INSTR wins the first tie. With inputs idle, all req/gnt/rvalid outputs are 0 and all data outputs are 0. Reset mid-operation discards outstanding entries; rvalids arriving after reset for those entries set proto_err_o.
- Selection (combinational):
  - If lock is set, sel=lock_owner.
  - Otherwise, if only one requester is active, sel is that requester.
  - If both are active, sel is the requester other than rr_last.
- Full blocking: when the FIFO is full, mem_req_o=0 and both gnt outputs are 0. A simultaneous pop does not unblock in the same cycle.
- Request mux: mem_req_o=sel_req & ~full.
  - INSTR selected: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0, mem_addr_o=instr_addr_i.
  - DATA selected: the data_* fields pass through to mem_*.
- Grant: sel_gnt_o=mem_gnt_i & mem_req_o, zero-latency. The non-selected gnt output is always 0.
- Lock: when mem_req_o=1 and mem_gnt_i=0, lock is set with lock_owner=sel. Lock clears on the cycle that grant occurs. The arbiter never switches address/owner while a request waits ungranted.
- On grant:
  - Push sel into the FIFO.
  - rr_last<=sel.
- Response routing:
  - When mem_rvalid_i=1 and the FIFO is non-empty, pop the head. Assert the head owner's rvalid_o for that cycle, with rdata_o=mem_rdata_i and err_o=mem_err_i.
  - The non-owner's rvalid_o, rdata_o and err_o are 0.
  - Zero added latency.
- Protocol error: mem_rvalid_i with the FIFO empty is ignored for routing (no rvalid output) and sets proto_err_o. proto_err_o is cleared only by rst_i.
- Simultaneous push and pop: occupancy is unchanged and ordering is preserved (the pop takes the older head).
- Pointer arithmetic: read/write pointers wrap modulo MaxOutstanding, and full/empty are derived from the count. Behaviour must be correct for MaxOutstanding=1 and for non-power-of-two depths.
- Requester withdrawal: if the requester deasserts req while ungranted (an Ibex protocol violation), lock clears next cycle. No assertion is required.

Test Plan:
- Reset then data_req_i=1 alone with mem_gnt_i=1 -> data_gnt_o=1 in the same cycle, mem_addr_o=data_addr_i, outstanding_o=1 next cycle; mem_rvalid_i=1 with rdata=32'hDEADBEEF -> data_rvalid_o=1, data_rdata_o=32'hDEADBEEF, instr_rvalid_o=0.
- Both requesting continuously, mem_gnt_i=1, rvalid one cycle after each grant -> grants alternate INSTR, DATA, INSTR, DATA. Instr grants show mem_we_o=0 and mem_be_o=4'hF.
- Lock check: DATA selected, mem_gnt_i held 0 for 3 cycles while instr_req_i=1 -> mem_addr_o stays data_addr_i and instr_gnt_o stays 0. On the 4th cycle mem_gnt_i=1 -> data granted, then INSTR is granted on the next cycle.
- MaxOutstanding=2: two grants with no rvalid -> outstanding_o=2 and mem_req_o=0 despite requests. Cycle with rvalid -> no grant that cycle, outstanding_o=1, grant resumes the next cycle. Responses route in order INSTR then DATA, with mem_err_i=1 on the second -> data_err_o=1.
- mem_rvalid_i=1 with an empty FIFO -> no rvalid output, proto_err_o=1 sticky. rst_i=1 for one cycle -> proto_err_o=0.
- Two outstanding transactions, then rst_i pulsed -> outstanding_o=0. A later stray rvalid sets proto_err_o and produces no rvalid output.

Source files
------------

// File: rtl/ibex_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between Ibex instruction fetch and LSU.
// Round-robin with request lock; an in-order owner FIFO steers responses back.
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_req_i,
    output logic            instr_gnt_o,
    output logic            instr_rvalid_o,
    input  logic [31:0]     instr_addr_i,
    output logic [31:0]     instr_rdata_o,
    output logic            instr_err_o,
    input  logic            data_req_i,
    output logic            data_gnt_o,
    output logic            data_rvalid_o,
    input  logic            data_we_i,
    input  logic [3:0]      data_be_i,
    input  logic [31:0]     data_addr_i,
    input  logic [31:0]     data_wdata_i,
    output logic [31:0]     data_rdata_o,
    output logic            data_err_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic [31:0]     mem_rdata_i,
    input  logic            mem_err_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            proto_err_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    owner_e          fifo_q [MaxOutstanding];
    owner_e          fifo_d [MaxOutstanding];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lock_q, lock_d;
    owner_e          lock_owner_q, lock_owner_d;
    owner_e          rr_last_q, rr_last_d;
    logic            proto_err_q, proto_err_d;

    owner_e sel;
    owner_e head;
    logic   sel_req, full, empty, push, pop;

    // Selection, request mux and grant
    always_comb begin
        full  = (cnt_q == CntW'(MaxOutstanding));
        empty = (cnt_q == '0);

        if (lock_q) begin
            sel = lock_owner_q;
        end else if (instr_req_i && !data_req_i) begin
            sel = OWN_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            sel = OWN_DATA;
        end else if (instr_req_i && data_req_i) begin
            sel = (rr_last_q == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        end else begin
            sel = OWN_INSTR;
        end

        sel_req   = (sel == OWN_INSTR) ? instr_req_i : data_req_i;
        mem_req_o = sel_req & ~full;

        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (sel_req) begin
            if (sel == OWN_INSTR) begin
                mem_be_o   = 4'hF;
                mem_addr_o = instr_addr_i;
            end else begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
        end

        push        = mem_req_o & mem_gnt_i;
        instr_gnt_o = push & (sel == OWN_INSTR);
        data_gnt_o  = push & (sel == OWN_DATA);
    end

    // Response routing to the owner at the FIFO head
    always_comb begin
        head = fifo_q[rptr_q];
        pop  = mem_rvalid_i & ~empty;

        instr_rvalid_o = pop & (head == OWN_INSTR);
        data_rvalid_o  = pop & (head == OWN_DATA);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
        instr_err_o    = instr_rvalid_o & mem_err_i;
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
        data_err_o     = data_rvalid_o & mem_err_i;
    end

    // Next-state: owner FIFO, lock, round-robin pointer, protocol error
    always_comb begin
        fifo_d       = fifo_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q + CntW'(push) - CntW'(pop);
        lock_d       = mem_req_o & ~mem_gnt_i;
        lock_owner_d = sel;
        rr_last_d    = rr_last_q;
        proto_err_d  = proto_err_q | (mem_rvalid_i & empty);

        if (push) begin
            fifo_d[wptr_q] = sel;
            wptr_d         = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
            rr_last_d      = sel;
        end
        if (pop) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q       <= '{default: OWN_INSTR};
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_INSTR;
            rr_last_q    <= OWN_DATA;
            proto_err_q  <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            rr_last_q    <= rr_last_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign proto_err_o   = proto_err_q;

endmodule
